// File: rtl/spi_mosi_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spi_mosi_tx_scheduler
// Purpose  : Round-robin arbiter in front of a single SPI mode-0 MOSI
//            transmitter. Each grant produces one complete frame:
//            chip-select setup, MSB-first shift, chip-select hold.
// Revision : 1.0 - initial release
// ============================================================================
module spi_mosi_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic                            done,
  output logic                            spi_sclk,
  output logic                            spi_mosi,
  output logic                            spi_cs_n
);

  localparam int ID_W     = $clog2(NUM_REQ);
  localparam int BIT_W    = $clog2(DATA_WIDTH + 1);
  localparam int DIV_W    = $clog2(CLK_DIV + 1);
  localparam int WAIT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_nx;
  logic [DIV_W-1:0]      div_cnt, div_cnt_nx;
  logic [WAIT_W-1:0]     wait_cnt, wait_cnt_nx;
  logic [ID_W-1:0]       last_grant, last_grant_nx;
  logic [ID_W-1:0]       grant_nx;
  logic                  busy_nx, done_nx, sclk_nx, cs_n_nx;

  // Arbitration results
  logic                  found;
  logic [ID_W-1:0]       win;
  int                    idx;
  logic [DATA_WIDTH-1:0] win_data;

  // MOSI is the MSB of the shift register; clearing the register idles the line low.
  assign spi_mosi = shreg[DATA_WIDTH-1];

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
    win_data = req_data[win*DATA_WIDTH +: DATA_WIDTH];
  end

  // Ready is offered only while idle, and only to the round-robin winner.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && found) begin
      req_ready[win] = 1'b1;
    end
  end

  // Frame sequencer: next state and next values of every registered output.
  always_comb begin
    state_nx      = state;
    shreg_nx      = shreg;
    bit_cnt_nx    = bit_cnt;
    div_cnt_nx    = div_cnt;
    wait_cnt_nx   = wait_cnt;
    last_grant_nx = last_grant;
    grant_nx      = grant_id;
    busy_nx       = busy;
    done_nx       = 1'b0;
    sclk_nx       = spi_sclk;
    cs_n_nx       = spi_cs_n;

    case (state)
      S_IDLE: begin
        if (found) begin
          shreg_nx      = win_data;
          grant_nx      = win;
          last_grant_nx = win;
          busy_nx       = 1'b1;
          cs_n_nx       = 1'b0;
          wait_cnt_nx   = '0;
          state_nx      = S_SETUP;
        end
      end

      S_SETUP: begin
        // The first cs_n-low cycle is SETUP cycle 0.
        if (wait_cnt == WAIT_W'(CS_SETUP - 1)) begin
          wait_cnt_nx = '0;
          div_cnt_nx  = '0;
          bit_cnt_nx  = '0;
          state_nx    = S_SHIFT;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end

      S_SHIFT: begin
        if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
          div_cnt_nx = '0;
          sclk_nx    = ~spi_sclk;
          if (spi_sclk) begin
            // Falling edge: either the frame's last bit is done, or present the next bit.
            if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
              wait_cnt_nx = '0;
              state_nx    = S_HOLD;
            end else begin
              bit_cnt_nx = bit_cnt + 1'b1;
              shreg_nx   = {shreg[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end else begin
          div_cnt_nx = div_cnt + 1'b1;
        end
      end

      S_HOLD: begin
        if (wait_cnt == WAIT_W'(CS_HOLD - 1)) begin
          cs_n_nx  = 1'b1;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          shreg_nx = '0;
          state_nx = S_IDLE;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      wait_cnt   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      spi_sclk   <= 1'b0;
      spi_cs_n   <= 1'b1;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      bit_cnt    <= bit_cnt_nx;
      div_cnt    <= div_cnt_nx;
      wait_cnt   <= wait_cnt_nx;
      last_grant <= last_grant_nx;
      grant_id   <= grant_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      spi_sclk   <= sclk_nx;
      spi_cs_n   <= cs_n_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_mosi_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_mosi_tx_scheduler
// Purpose  : Self-checking bench for spi_mosi_tx_scheduler: cycle model of
//            frame timing, RR vector table, directed corner sequences and
//            randomized request traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_mosi_tx_scheduler;

  localparam int NR  = 4;
  localparam int DW  = 16;
  localparam int CD  = 4;
  localparam int CSS = 2;
  localparam int CSH = 2;
  localparam int SH  = 2 * CD * DW;
  localparam int L   = CSS + SH + CSH;
  localparam int IDW = $clog2(NR);

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic [IDW-1:0]    grant_id;
  logic              busy, done, spi_sclk, spi_mosi, spi_cs_n;

  // Second instance with the minimal timing parameters.
  logic              rst2 = 1'b1;
  logic [1:0]        valid2 = '0;
  logic [15:0]       data2 = '0;
  logic [1:0]        ready2;
  logic [0:0]        gid2;
  logic              busy2, done2, sclk2, mosi2, cs2;

  always #5 ACLK = ~ACLK;

  spi_mosi_tx_scheduler #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .CLK_DIV(CD), .CS_SETUP(CSS), .CS_HOLD(CSH)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant_id(grant_id), .busy(busy), .done(done),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n)
  );

  spi_mosi_tx_scheduler #(
    .NUM_REQ(2), .DATA_WIDTH(8), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)
  ) dut2 (
    .ACLK(ACLK), .ARESET(rst2), .req_valid(valid2), .req_data(data2),
    .req_ready(ready2), .grant_id(gid2), .busy(busy2), .done(done2),
    .spi_sclk(sclk2), .spi_mosi(mosi2), .spi_cs_n(cs2)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    int i;
    for (int k = 1; k <= NR; k++) begin
      i = (last + k) % NR;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // ---------------- reference model: frame timeline ----------------
  bit            m_en = 1'b0;
  bit            m_active = 1'b0;
  bit            m_done = 1'b0;
  int            m_cyc = 0;
  int            m_grant = 0;
  int            m_last = NR - 1;
  logic [DW-1:0] m_data = '0;

  always @(posedge ACLK) begin : model
    int  w;
    bit  was_idle;
    if (ARESET) begin
      m_en = 1'b1; m_active = 1'b0; m_done = 1'b0; m_cyc = 0;
      m_grant = 0; m_last = NR - 1; m_data = '0;
    end else if (m_en) begin
      was_idle = !m_active;
      m_done   = 1'b0;
      if (m_active) begin
        m_cyc++;
        if (m_cyc == L + 1) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
      if (was_idle) begin
        w = rr_pick(req_valid, m_last);
        if (w >= 0) begin
          m_active = 1'b1; m_cyc = 1; m_grant = w; m_last = w;
          m_data = req_data[w*DW +: DW];
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge ACLK) begin : cycle_check
    logic [NR-1:0] e_ready;
    logic          e_sclk, e_mosi;
    int            s, j, w;
    if (m_en) begin
      e_ready = '0; e_sclk = 1'b0; e_mosi = 1'b0;
      if (m_active) begin
        s = m_cyc - 1;
        if (s < CSS) begin
          e_mosi = m_data[DW-1];
        end else if (s < CSS + SH) begin
          j = s - CSS;
          e_sclk = ((j / CD) % 2) == 1;
          e_mosi = m_data[DW - 1 - j / (2 * CD)];
        end else begin
          e_mosi = m_data[0];
        end
      end else begin
        w = rr_pick(req_valid, m_last);
        if (w >= 0) e_ready[w] = 1'b1;
      end
      check("cycle{ready,gid,busy,done,sclk,mosi,cs_n}",
            {req_ready, grant_id, busy, done, spi_sclk, spi_mosi, spi_cs_n},
            {e_ready, IDW'(m_grant), m_active, m_done, e_sclk, e_mosi, !m_active});
    end
  end

  // ---------------- observation monitors ----------------
  int   cyc = 0;
  bit   bit_q[$];
  int   done_q[$];
  int   done_cyc_q[$];
  int   acc_cyc_q[$];
  int   lo_q[$];
  int   hi_q[$];
  int   lo_cnt = 0, hi_cnt = 0;
  int   rdy_cnt [NR];
  logic prev_sclk = 1'b0;

  always @(negedge ACLK) begin : monitors
    cyc++;
    if (m_en) begin
      if (spi_sclk === 1'b1 && prev_sclk === 1'b0) bit_q.push_back(spi_mosi);
      prev_sclk = spi_sclk;
      if (done === 1'b1) begin
        done_q.push_back(int'(grant_id));
        done_cyc_q.push_back(cyc);
      end
      if (|(req_ready & req_valid)) acc_cyc_q.push_back(cyc);
      for (int i = 0; i < NR; i++) if (req_ready[i] === 1'b1) rdy_cnt[i]++;
      if (spi_cs_n === 1'b1) begin
        hi_cnt++;
        if (lo_cnt > 0) begin lo_q.push_back(lo_cnt); lo_cnt = 0; end
      end else begin
        lo_cnt++;
        if (hi_cnt > 0) begin hi_q.push_back(hi_cnt); hi_cnt = 0; end
      end
    end
  end

  task automatic clear_mon();
    bit_q.delete(); done_q.delete(); done_cyc_q.delete(); acc_cyc_q.delete();
    lo_q.delete(); hi_q.delete(); lo_cnt = 0; hi_cnt = 0;
    for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    req_valid = '0;
    repeat (2) tick();
    ARESET = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int c;
    c = 0;
    while (done_q.size() < n && c < budget) begin tick(); c++; end
    if (done_q.size() < n) check("done_timeout", 64'(done_q.size()), 64'(n));
  endtask

  function automatic logic [DW-1:0] frame_word(input int base);
    logic [DW-1:0] w;
    w = '0;
    for (int b = 0; b < DW; b++) w = {w[DW-2:0], (base + b < bit_q.size()) ? bit_q[base + b] : 1'b0};
    return w;
  endfunction

  typedef struct packed {
    logic [NR-1:0] valid;
    logic [NR-1:0] exp_ready;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl [7];
    int   exp2 [5];
    int   exp3 [5];
    int   c, low, rises, bad, dn, lastrise, perbad;
    logic ps;

    tbl[0] = '{valid: 4'b0000, exp_ready: 4'b0000};
    tbl[1] = '{valid: 4'b0001, exp_ready: 4'b0001};
    tbl[2] = '{valid: 4'b1000, exp_ready: 4'b1000};
    tbl[3] = '{valid: 4'b1010, exp_ready: 4'b0010};
    tbl[4] = '{valid: 4'b1100, exp_ready: 4'b0100};
    tbl[5] = '{valid: 4'b1111, exp_ready: 4'b0001};
    tbl[6] = '{valid: 4'b0110, exp_ready: 4'b0010};
    exp2 = '{0, 1, 2, 3, 0};
    exp3 = '{1, 3, 1, 3, 1};
    clear_mon();

    // Reset state
    do_reset();
    check("rst_cs_n", spi_cs_n, 1'b1);
    check("rst_sclk", spi_sclk, 1'b0);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_grant_id", grant_id, '0);

    // Round-robin winner table from the reset pointer (requester 0 first)
    for (int t = 0; t < 7; t++) begin
      req_valid = tbl[t].valid;
      #1;
      check($sformatf("rr_table[%0d]", t), req_ready, tbl[t].exp_ready);
      req_valid = '0;
      tick();
    end

    // Minimal-parameter frame: CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, 8 bits of 1s
    tick();
    rst2 = 1'b0;
    data2 = 16'h00FF;
    valid2 = 2'b01;
    #1;
    check("p5_ready", ready2, 2'b01);
    tick();
    valid2 = '0;
    low = 0; rises = 0; bad = 0; dn = 0; lastrise = -1; perbad = 0; ps = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge ACLK);
      if (cs2 === 1'b0) begin
        low++;
        if (mosi2 !== 1'b1) bad++;
      end
      if (sclk2 === 1'b1 && ps === 1'b0) begin
        if (lastrise >= 0 && k - lastrise != 2) perbad++;
        lastrise = k;
        rises++;
      end
      ps = sclk2;
      if (done2 === 1'b1) dn++;
    end
    check("p5_cs_low_cycles", low, 18);
    check("p5_sclk_rises", rises, 8);
    check("p5_sclk_period_bad", perbad, 0);
    check("p5_mosi_not_one", bad, 0);
    check("p5_done_pulses", dn, 1);
    check("p5_cs_idle", cs2, 1'b1);

    // Single frame A5C3 from requester 0
    do_reset();
    clear_mon();
    req_data[15:0] = 16'hA5C3;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    wait_done(1, 300);
    tick();
    check("t1_bits", bit_q.size(), DW);
    check("t1_mosi_word", frame_word(0), 16'hA5C3);
    check("t1_cs_low", (lo_q.size() > 0) ? lo_q[0] : -1, 132);
    check("t1_latency", (done_cyc_q.size() > 0 && acc_cyc_q.size() > 0) ?
          done_cyc_q[0] - acc_cyc_q[0] : -1, 133);
    check("t1_grant", (done_q.size() > 0) ? done_q[0] : -1, 0);
    check("t1_ready_pulses", rdy_cnt[0], 1);

    // All four requesters valid from reset
    do_reset();
    clear_mon();
    req_data = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    req_valid = 4'b1111;
    wait_done(5, 5 * (L + 2) + 20);
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2_grant[%0d]", k), (k < done_q.size()) ? done_q[k] : -1, exp2[k]);
      check($sformatf("t2_data[%0d]", k), frame_word(16 * k), DW'(exp2[k] + 1));
    end
    for (int k = 1; k < 5; k++)
      check($sformatf("t2_gap[%0d]", k), (k < hi_q.size()) ? hi_q[k] : -1, 1);

    // Fairness between requesters 1 and 3
    do_reset();
    clear_mon();
    req_valid = 4'b1010;
    wait_done(5, 5 * (L + 2) + 20);
    req_valid = '0;
    for (int k = 0; k < 5; k++)
      check($sformatf("t3_grant[%0d]", k), (k < done_q.size()) ? done_q[k] : -1, exp3[k]);

    // Reset after the 7th rising SCLK edge
    do_reset();
    clear_mon();
    req_data[31:16] = 16'h5A5A;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    c = 0;
    while (bit_q.size() < 7 && c < 200) begin tick(); c++; end
    check("t4_reached_7_edges", bit_q.size() >= 7, 1'b1);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    check("t4_cs_n", spi_cs_n, 1'b1);
    check("t4_sclk", spi_sclk, 1'b0);
    check("t4_mosi", spi_mosi, 1'b0);
    check("t4_busy", busy, 1'b0);
    repeat (5) tick();
    check("t4_no_done", done_q.size(), 0);
    req_valid = 4'b1011;
    #1;
    check("t4_next_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    wait_done(1, 300);
    check("t4_next_grant", (done_q.size() > 0) ? done_q[0] : -1, 0);

    // Request withdrawn while busy
    do_reset();
    clear_mon();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (20) tick();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    wait_done(1, 300);
    repeat (10) tick();
    check("t6_ready2_count", rdy_cnt[2], 0);
    check("t6_done_count", done_q.size(), 1);
    check("t6_grant", (done_q.size() > 0) ? done_q[0] : -1, 0);

    // Randomized traffic, checked cycle by cycle against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(7) == 0) begin
            req_data[i*DW +: DW] = DW'($urandom);
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(63) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      ARESET = ($urandom_range(2499) == 0);
      tick();
    end
    ARESET = 1'b0;
    req_valid = '0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
